// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES-CTR sequencer.
// Optional byte-keep support is enabled with AES_CTR_BYTE_KEEP_EN.
package aes_ctr_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_KEY_W   = 256;
    localparam int unsigned AES_KEEP_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_KEY_INIT  = 3'd1,
        S_KEY_WAIT  = 3'd2,
        S_RUN       = 3'd3,
        S_BLK_START = 3'd4,
        S_BLK_WAIT  = 3'd5,
        S_OUT       = 3'd6
    } aes_ctr_state_e;

    // One captured input beat awaiting its keystream block.
    typedef struct packed {
        logic [AES_BLOCK_W-1:0] data;
        logic                   last;
    } aes_ctr_beat_t;

    // Expand a per-byte keep vector into a per-bit data mask.
    function automatic logic [AES_BLOCK_W-1:0] keep_to_mask(input logic [AES_KEEP_W-1:0] keep);
        logic [AES_BLOCK_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < int'(AES_KEEP_W); i++) begin
            mask[8*i +: 8] = {8{keep[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/aes_ctr_counter.sv
// CTR counter block: loads from the IV and increments only its low CTR_WIDTH bits.
module aes_ctr_counter
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [AES_BLOCK_W-1:0] i_iv,
    input  logic                   i_inc,
    output logic [AES_BLOCK_W-1:0] o_ctr
);

    logic [AES_BLOCK_W-1:0] r_ctr;
    logic [AES_BLOCK_W-1:0] w_ctr_inc;

    // Upper bits pass through untouched; the low field wraps silently.
    generate
        if (CTR_WIDTH >= AES_BLOCK_W) begin : gen_full
            assign w_ctr_inc = r_ctr + AES_BLOCK_W'(1);
        end else begin : gen_part
            assign w_ctr_inc = {r_ctr[AES_BLOCK_W-1:CTR_WIDTH],
                                r_ctr[CTR_WIDTH-1:0] + CTR_WIDTH'(1)};
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctr <= '0;
        end else if (i_load) begin
            r_ctr <= i_iv;
        end else if (i_inc) begin
            r_ctr <= w_ctr_inc;
        end
    end

    assign o_ctr = r_ctr;

endmodule

// File: rtl/aes_ctr_sequencer.sv
// AES-CTR stream sequencer driving an external aes_core, one block in flight.
// Optional byte-keep ports are enabled with AES_CTR_BYTE_KEEP_EN.
module aes_ctr_sequencer
    import aes_ctr_pkg::*;
#(
    parameter int unsigned CTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cfg_start,
    input  logic [AES_KEY_W-1:0]   cfg_key,
    input  logic                   cfg_keylen,
    input  logic [AES_BLOCK_W-1:0] cfg_iv,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic                   in_last,
`ifdef AES_CTR_BYTE_KEEP_EN
    input  logic [AES_KEEP_W-1:0]  in_keep,
    output logic [AES_KEEP_W-1:0]  out_keep,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic                   out_last,
    output logic                   aes_init,
    output logic                   aes_next,
    output logic                   aes_encdec,
    output logic [AES_KEY_W-1:0]   aes_key,
    output logic                   aes_keylen,
    output logic [AES_BLOCK_W-1:0] aes_block,
    input  logic                   aes_ready,
    input  logic [AES_BLOCK_W-1:0] aes_result,
    input  logic                   aes_result_valid
);

    aes_ctr_state_e         r_state;
    aes_ctr_state_e         w_state_nxt;
    logic                   r_armed;
    logic                   w_armed_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic                   r_aes_init;
    logic                   w_aes_init_nxt;
    logic                   r_aes_next;
    logic                   w_aes_next_nxt;
    logic                   r_out_valid;
    logic                   w_out_valid_nxt;

    logic [AES_KEY_W-1:0]   r_key;
    logic                   r_keylen;
    aes_ctr_beat_t          r_beat;
    logic [AES_BLOCK_W-1:0] r_out_data;
    logic                   r_out_last;
    logic [AES_BLOCK_W-1:0] w_out_data_nxt;

    logic                   w_cfg_acc;
    logic                   w_in_acc;
    logic                   w_res_acc;
    logic [AES_BLOCK_W-1:0] w_ctr;

    // Handshake qualifiers; r_armed masks the first cycle of each wait state.
    assign w_cfg_acc = (r_state == S_IDLE) && cfg_start;
    assign w_in_acc  = (r_state == S_RUN) && in_valid;
    assign w_res_acc = (r_state == S_BLK_WAIT) && r_armed && aes_ready && aes_result_valid;

`ifdef AES_CTR_BYTE_KEEP_EN
    logic [AES_KEEP_W-1:0]  r_keep;
    logic [AES_KEEP_W-1:0]  r_out_keep;

    assign w_out_data_nxt = (r_beat.data ^ aes_result) & keep_to_mask(r_keep);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_keep     <= '0;
            r_out_keep <= '0;
        end else begin
            if (w_in_acc) begin
                r_keep <= in_keep;
            end
            if (w_res_acc) begin
                r_out_keep <= r_keep;
            end
        end
    end

    assign out_keep = r_out_keep;
`else
    assign w_out_data_nxt = r_beat.data ^ aes_result;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_armed     <= 1'b0;
            r_busy      <= 1'b0;
            r_aes_init  <= 1'b0;
            r_aes_next  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_armed     <= w_armed_nxt;
            r_busy      <= w_busy_nxt;
            r_aes_init  <= w_aes_init_nxt;
            r_aes_next  <= w_aes_next_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_armed_nxt     = 1'b0;
        w_busy_nxt      = 1'b0;
        w_aes_init_nxt  = 1'b0;
        w_aes_next_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = S_KEY_INIT;
                end
            end
            S_KEY_INIT: begin
                w_state_nxt = S_KEY_WAIT;
            end
            S_KEY_WAIT: begin
                if (r_armed && aes_ready) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    w_state_nxt = S_BLK_START;
                end
            end
            S_BLK_START: begin
                w_state_nxt = S_BLK_WAIT;
            end
            S_BLK_WAIT: begin
                if (w_res_acc) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_state_nxt = r_beat.last ? S_IDLE : S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Registered outputs mirror the state being entered.
        w_armed_nxt     = ((r_state == S_KEY_WAIT) || (r_state == S_BLK_WAIT)) &&
                          (w_state_nxt == r_state);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_aes_init_nxt  = (w_state_nxt == S_KEY_INIT);
        w_aes_next_nxt  = (w_state_nxt == S_BLK_START);
        w_out_valid_nxt = (w_state_nxt == S_OUT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key      <= '0;
            r_keylen   <= 1'b0;
            r_beat     <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            if (w_cfg_acc) begin
                r_key    <= cfg_key;
                r_keylen <= cfg_keylen;
            end
            if (w_in_acc) begin
                r_beat <= aes_ctr_beat_t'{data: in_data, last: in_last};
            end
            if (w_res_acc) begin
                r_out_data <= w_out_data_nxt;
                r_out_last <= r_beat.last;
            end
        end
    end

    aes_ctr_counter #(
        .CTR_WIDTH (CTR_WIDTH)
    ) u_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_cfg_acc),
        .i_iv    (cfg_iv),
        .i_inc   (w_res_acc),
        .o_ctr   (w_ctr)
    );

    assign in_ready   = (r_state == S_RUN);
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign aes_init   = r_aes_init;
    assign aes_next   = r_aes_next;
    assign aes_encdec = 1'b1;
    assign aes_key    = r_key;
    assign aes_keylen = r_keylen;
    assign aes_block  = w_ctr;

endmodule

// File: tb/tb_aes_ctr_sequencer.sv
// Directed bench for aes_ctr_sequencer with a behavioural aes_core stand-in.
// Keep-path steps are included when AES_CTR_BYTE_KEEP_EN is defined.
module tb_aes_ctr_sequencer;

    localparam int unsigned LAT = 5;
    localparam int unsigned TMO = 200;

    localparam logic [255:0] NIST_KEY = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [127:0] NIST_CTR [4] = '{
        128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00,
        128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff01, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff02};
    localparam logic [127:0] NIST_PT [4] = '{
        128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
        128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
    localparam logic [127:0] NIST_CT [4] = '{
        128'h874d6191b620e3261bef6864990db6ce, 128'h9806f66b7970fdff8617187bb9fffdff,
        128'h5ae4df3edbd5d35e5b4f09020db03eab, 128'h1e031dda2fbe03d1792170a0f3009cee};
    localparam logic [255:0] K2      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] WRAP_IV = {96'ha5a5a5a5a5a5a5a5a5a5a5a5, 32'hffffffff};

    logic         clk;
    logic         reset_n;
    logic         cfg_start;
    logic [255:0] cfg_key;
    logic         cfg_keylen;
    logic [127:0] cfg_iv;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         aes_init;
    logic         aes_next;
    logic         aes_encdec;
    logic [255:0] aes_key;
    logic         aes_keylen;
    logic [127:0] aes_block;
    logic         aes_ready;
    logic [127:0] aes_result;
    logic         aes_result_valid;
`ifdef AES_CTR_BYTE_KEEP_EN
    logic [15:0]  in_keep;
    logic [15:0]  out_keep;
`endif

    int           n_pass  = 0;
    int           n_total = 0;
    int           n_fail  = 0;
    logic [128:0] sb[$];

    aes_ctr_sequencer #(.CTR_WIDTH(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cfg_start        (cfg_start),
        .cfg_key          (cfg_key),
        .cfg_keylen       (cfg_keylen),
        .cfg_iv           (cfg_iv),
        .busy             (busy),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
`ifdef AES_CTR_BYTE_KEEP_EN
        .in_keep          (in_keep),
        .out_keep         (out_keep),
`endif
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_last         (out_last),
        .aes_init         (aes_init),
        .aes_next         (aes_next),
        .aes_encdec       (aes_encdec),
        .aes_key          (aes_key),
        .aes_keylen       (aes_keylen),
        .aes_block        (aes_block),
        .aes_ready        (aes_ready),
        .aes_result       (aes_result),
        .aes_result_valid (aes_result_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keystream stand-in: true AES for the NIST key/counters, an arbitrary mix otherwise.
    function automatic logic [127:0] ks(input logic [255:0] key, input logic keylen,
                                        input logic [127:0] blk);
        if (key == NIST_KEY && !keylen) begin
            for (int i = 0; i < 4; i++) begin
                if (blk == NIST_CTR[i]) return NIST_PT[i] ^ NIST_CT[i];
            end
        end
        return blk ^ key[255:128] ^ (keylen ? key[127:0] : 128'h0) ^ {blk[63:0], blk[127:64]}
               ^ 128'h0123456789abcdeffedcba9876543210;
    endfunction

    function automatic logic [127:0] keep_mask(input logic [15:0] k);
        logic [127:0] m;
        for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // aes_core model: ready/result_valid drop one cycle after init/next, return after LAT.
    int           m_cnt;
    logic         m_is_next;
    logic [127:0] m_blk;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aes_ready        <= 1'b1;
            aes_result_valid <= 1'b0;
            aes_result       <= '0;
            m_cnt            <= 0;
            m_is_next        <= 1'b0;
            m_blk            <= '0;
        end else if (aes_init || aes_next) begin
            m_cnt     <= LAT;
            m_is_next <= aes_next;
            m_blk     <= aes_block;
        end else if (m_cnt != 0) begin
            m_cnt     <= m_cnt - 1;
            aes_ready <= 1'b0;
            if (m_is_next) aes_result_valid <= 1'b0;
            if (m_cnt == 1) begin
                aes_ready <= 1'b1;
                if (m_is_next) begin
                    aes_result_valid <= 1'b1;
                    aes_result       <= ks(aes_key, aes_keylen, m_blk);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_last"},  out_last, 0);
        check({tag, "_aes_init"},  aes_init, 0);
        check({tag, "_aes_next"},  aes_next, 0);
        check({tag, "_keylen"},    aes_keylen, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_encdec"},    aes_encdec, 1);
        check({tag, "_out_data"},  out_data, 0);
        check({tag, "_aes_key"},   aes_key, 0);
        check({tag, "_aes_block"}, aes_block, 0);
`ifdef AES_CTR_BYTE_KEEP_EN
        check({tag, "_out_keep"},  out_keep, 0);
`endif
    endtask

    task automatic wait_in_ready();
        int i = 0;
        while (!in_ready && i < int'(TMO)) begin
            @(negedge clk);
            i++;
        end
        check("in_ready_wait", in_ready, 1);
    endtask

    task automatic configure(input logic [255:0] key, input logic keylen, input logic [127:0] iv);
        cfg_key    = key;
        cfg_keylen = keylen;
        cfg_iv     = iv;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start  = 1'b0;
        check("cfg_busy", busy, 1);
        check("cfg_init", aes_init, 1);
        check("cfg_key", aes_key, key);
        check("cfg_keylen", aes_keylen, keylen);
        check("cfg_iv", aes_block, iv);
        @(negedge clk);
        check("cfg_init_once", aes_init, 0);
        wait_in_ready();
    endtask

    // One block through the DUT; exp is the unmasked ciphertext, bp the out_ready stall.
    task automatic xfer(input logic [127:0] data, input logic last, input logic [15:0] keep,
                        input int bp, input logic [127:0] exp);
        logic [128:0] e;
        logic [127:0] held;
        logic         bad;
        logic         found;
        sb.push_back({last, exp & keep_mask(keep)});
        wait_in_ready();
        in_valid = 1'b1;
        in_data  = data;
        in_last  = last;
`ifdef AES_CTR_BYTE_KEEP_EN
        in_keep  = keep;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        check("aes_next_t1", aes_next, 1);
        @(negedge clk);
        found = 1'b0;
        for (int i = 0; i < int'(TMO) && !found; i++) begin
            @(negedge clk);
            found = aes_ready && aes_result_valid;
        end
        check("result_wait", found, 1);
        check("out_valid_r", out_valid, 0);
        @(negedge clk);
        check("out_valid_r1", out_valid, 1);
        held = out_data;
        bad  = 1'b0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (!out_valid || out_data !== held || in_ready || aes_next) bad = 1'b1;
        end
        if (bp > 0) check("backpressure_hold", bad, 0);
        e = sb.pop_front();
        check("out_data", out_data, e[127:0]);
        check("out_last", out_last, e[128]);
`ifdef AES_CTR_BYTE_KEEP_EN
        check("out_keep", out_keep, keep);
`endif
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 0);
        if (last) check("busy_fall", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        cfg_start  = 1'b0;
        cfg_key    = '0;
        cfg_keylen = 1'b0;
        cfg_iv     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        out_ready  = 1'b0;
`ifdef AES_CTR_BYTE_KEEP_EN
        in_keep    = 16'hffff;
`endif
        repeat (2) @(negedge clk);
        check_reset("por");
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", in_ready, 0);

        // NIST F.5.1 single block
        configure(NIST_KEY, 1'b0, NIST_CTR[0]);
        xfer(NIST_PT[0], 1'b1, 16'hffff, 0, NIST_CT[0]);

        // Four-block stream, stall on block 2, ignored cfg_start before block 3
        configure(NIST_KEY, 1'b0, NIST_CTR[0]);
        for (int b = 0; b < 4; b++) begin
            wait_in_ready();
            check("ctr_step", aes_block, NIST_CTR[b]);
            if (b == 2) begin
                cfg_key   = K2;
                cfg_iv    = WRAP_IV;
                cfg_start = 1'b1;
                @(negedge clk);
                cfg_start = 1'b0;
                check("ign_cfg_key", aes_key, NIST_KEY);
                check("ign_cfg_ctr", aes_block, NIST_CTR[2]);
                check("ign_cfg_init", aes_init, 0);
                check("ign_cfg_ready", in_ready, 1);
            end
            xfer(NIST_PT[b], (b == 3), 16'hffff, (b == 1) ? 10 : 0, NIST_CT[b]);
        end

        // Low-word wrap with AES-256 key
        configure(K2, 1'b1, WRAP_IV);
        xfer(128'hdeadbeef00112233445566778899aabb, 1'b1, 16'hffff, 0,
             128'hdeadbeef00112233445566778899aabb ^ ks(K2, 1'b1, WRAP_IV));
        check("wrap_ctr", aes_block, {96'ha5a5a5a5a5a5a5a5a5a5a5a5, 32'h00000000});

        // Reset while waiting for the core
        configure(NIST_KEY, 1'b0, NIST_CTR[0]);
        in_valid = 1'b1;
        in_data  = NIST_PT[0];
        in_last  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_pre_next", aes_next, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        configure(NIST_KEY, 1'b0, NIST_CTR[0]);
        xfer(NIST_PT[0], 1'b1, 16'hffff, 0, NIST_CT[0]);

`ifdef AES_CTR_BYTE_KEEP_EN
        // Upper eight bytes dropped by keep
        configure(NIST_KEY, 1'b0, NIST_CTR[0]);
        xfer(NIST_PT[0], 1'b1, 16'h00ff, 0, NIST_CT[0]);
`endif

        check("sb_empty", 256'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/aes_ctr_sequencer.md
# aes_ctr_sequencer

Upstream driver for `aes_core` that runs AES in CTR mode over a valid/ready stream of 128-bit data blocks. It loads key and IV, then sequences the core's `init`/`next`/`ready`/`result_valid` handshake. It XORs each keystream block with the captured input block and presents the result downstream. Exactly one AES block is in flight at a time.

## Interface
Parameters:
- `CTR_WIDTH`, default 32: low bits of the counter block that increment; range 1..128.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: single-cycle request to latch key/keylen/IV and expand the key. Honoured only in IDLE.
- `cfg_key` in 256: key. A 128-bit key sits in [255:128].
- `cfg_keylen` in 1: 0 = AES-128, 1 = AES-256.
- `cfg_iv` in 128: initial counter block.
- `busy` out 1: high whenever state != IDLE.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 128, `in_last` in 1: plaintext/ciphertext stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 128, `out_last` out 1: result stream.
- `aes_init` out 1, `aes_next` out 1, `aes_encdec` out 1, `aes_key` out 256, `aes_keylen` out 1, `aes_block` out 128: to `aes_core`.
- `aes_ready` in 1, `aes_result` in 128, `aes_result_valid` in 1: from `aes_core`.

## Operation
- `aes_encdec` is tied to 1 (encrypt); CTR decryption is the same operation.
- `aes_key`/`aes_keylen` are driven from registers latched on an accepted `cfg_start`.
- `aes_block` is driven from the counter register `ctr`.
- States:
  - IDLE: `cfg_start` latches key, keylen and `ctr <= cfg_iv`, then goes to KEY_INIT.
  - KEY_INIT: `aes_init=1` for exactly one cycle, then KEY_WAIT.
  - KEY_WAIT: `aes_ready` is ignored on the first cycle; afterwards `aes_ready=1` moves to RUN.
  - RUN: `in_ready=1`. On handshake, capture `in_data`/`in_last` into `dreg`/`lreg`, then BLK_START.
  - BLK_START: `aes_next=1` for one cycle, then BLK_WAIT.
  - BLK_WAIT: first cycle ignored; then `aes_ready & aes_result_valid` loads `out_data <= dreg ^ aes_result` and `out_last <= lreg`, sets `out_valid`, increments `ctr`, and goes to OUT.
  - OUT: hold all outputs until `out_ready`. On handshake, `lreg=0` goes to RUN and `lreg=1` goes to IDLE.
- Counter increment: `ctr[CTR_WIDTH-1:0] <= ctr[CTR_WIDTH-1:0] + 1`, modulo 2^CTR_WIDTH. Upper bits are never modified. Wrap is silent.
- `cfg_start` outside IDLE is ignored. Key and IV are unaffected.
- A new key or IV always requires IDLE, reached by a `last` block or by reset.

## Timing
- Reset values:
  - `in_ready`, `out_valid`, `out_last`, `aes_init`, `aes_next`, `aes_keylen`, `busy`: 0.
  - `aes_encdec`: 1.
  - `out_data`, `aes_key`, `aes_block`: all zeros.
  - State: IDLE.
- Reset mid-operation abandons the in-flight block; nothing is emitted. `aes_core` shares `reset_n`.
- `in_ready` is combinational from state only. It is never combinational from `in_valid`.
- All other outputs are registered.
- `in_data` is accepted in cycle T. Then `aes_next` is high in T+1. With the first cycle of `aes_ready` high and `aes_result_valid` in cycle R, `out_valid` rises in R+1.
- `out_valid` stays high with stable data until `out_ready`. `in_ready` is low during OUT, so there is no simultaneous accept/emit.
- `cfg_start` and `busy`: `busy` rises the cycle after the accepted `cfg_start`. It falls the cycle after the `last` output handshake.

## Configuration
`AES_CTR_BYTE_KEEP_EN` adds ports `in_keep` in 16 and `out_keep` out 16 (bit i covers `data[8i+7:8i]`).
- **Defined:** `in_keep` is captured with `in_data`. Bytes with keep=0 are forced to 0 in `out_data`. `out_keep` is the registered copy and resets to 0.
- **Undefined:** the ports are absent and all 16 bytes are always valid.

## Structure
- `aes_ctr_pkg` holds:
  - the state enum `aes_ctr_state_e`;
  - constants `AES_BLOCK_W=128`, `AES_KEY_W=256`, `AES_KEEP_W=16`.
- One sub-module, `aes_ctr_counter`: holds `ctr`, with load-from-IV, increment enable and `CTR_WIDTH`-bit partial increment.
- `aes_core` is instantiated alongside this block, not inside it.

## Test plan
- **NIST SP800-38A F.5.1, AES-128 single block.**
  - Stimulus: key `2b7e151628aed2a6abf7158809cf4f3c` (in [255:128]), IV `f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff`, data `6bc1bee22e409f96e93d7e117393172a`, last=1.
  - Required response: `out_data=874d6191b620e3261bef6864990db6ce`, `out_last=1`, then `busy` falls.
- **F.5.1 four-block stream.** Blocks 2–4 give `9806f66b7970fdff8617187bb9fffdff`, `5ae4df3edbd5d35e5b4f09020db03eab`, `1e031dda2fbe03d1792170a0f3009cee`. The IV low word steps `fcfdfeff`→`fcfdff00`→`fcfdff01`→`fcfdff02`.
- **Wrap, `CTR_WIDTH=32`.** IV `...ffffffff` (upper 96 bits `a5` pattern). After one block, `aes_block` low word is `00000000` and the upper 96 bits are unchanged.
- **Backpressure.** `out_ready=0` for 10 cycles. Then `out_valid`/`out_data` are stable, `in_ready=0`, and no `aes_next` pulse occurs.
- **Reset mid-BLK_WAIT.**
  - Assert `reset_n=0`. All outputs take their reset values and state is IDLE.
  - Repeat the F.5.1 block 1 after reset; the output matches the expected ciphertext.
- **Ignored `cfg_start` in RUN, plus keep handling.**
  - Pulse `cfg_start` with a different key in RUN. The output still matches the original key.
  - With `AES_CTR_BYTE_KEEP_EN`, `in_keep=16'h00ff` yields upper 8 bytes = 0.
